// File: rtl/round_referee.sv
// round_referee -- sequencer for a two-player quick-draw round.
//
// A round starts from IDLE on start, counts down WAIT_CYCLES, then opens a
// reaction window of WINDOW_CYCLES with draw high. The first fire edge wins
// and the other player is shot. A fire edge during the countdown is a false
// start and shoots the player who fired. If the window closes with no fire
// edge, both players are shot. The decision is presented on shot_p1/shot_p2
// one cycle before the single roundtime strobe. It is then held for
// RESULT_CYCLES, after which the lives inputs decide between another round
// and game over.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin a round (only honoured in IDLE)
//   p1_fire, p2_fire     player buttons, level, edge-detected internally
//   p1_lives, p2_lives   life counts from the external life counters
//   draw                 high while the reaction window is open
//   shot_p1, shot_p2     player loses a life this round
//   roundtime            one-cycle strobe for the life counters
//   game_over, winner    final result: 01 P1, 10 P2, 11 both out
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// COUNTDOWN | WAIT_CYCLES delay; any fire edge is a false start
// DRAW      | reaction window open, draw high
// RESOLVE   | decision visible on shot_*, no strobe yet
// STROBE    | roundtime high for one cycle
// RESULT    | shot_* held for RESULT_CYCLES, then lives evaluated
// GAMEOVER  | game_over/winner held until reset

module round_referee #(
   parameter int WAIT_CYCLES   = 50_000_000,
   parameter int WINDOW_CYCLES = 100_000_000,
   parameter int RESULT_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       p1_fire,
   input  logic       p2_fire,
   input  logic [1:0] p1_lives,
   input  logic [1:0] p2_lives,
   output logic       draw,
   output logic       shot_p1,
   output logic       shot_p2,
   output logic       roundtime,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int MAX_AB     = (WAIT_CYCLES > WINDOW_CYCLES) ? WAIT_CYCLES : WINDOW_CYCLES;
   localparam int MAX_CYCLES = (MAX_AB > RESULT_CYCLES) ? MAX_AB : RESULT_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES);

   // Counters are loaded with N-1 and leave their state on the cycle they
   // read zero, so each timed state lasts exactly N cycles.
   localparam logic [CW-1:0] WAIT_LD   = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] WINDOW_LD = CW'(WINDOW_CYCLES - 1);
   localparam logic [CW-1:0] RESULT_LD = CW'(RESULT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_DRAW      = 3'd2,
      S_RESOLVE   = 3'd3,
      S_STROBE    = 3'd4,
      S_RESULT    = 3'd5,
      S_GAMEOVER  = 3'd6
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          armed;
   logic          p1_q, p2_q;
   logic          e1, e2;
   logic          dec1, dec2;
   logic          draw_nxt, shot_p1_nxt, shot_p2_nxt, roundtime_nxt, game_over_nxt;
   logic [1:0]    winner_nxt;
   logic          cnt_zero;
   logic          p1_out, p2_out;

   // History registers run every cycle, so a button held across a state
   // boundary never produces an edge; it must be released and re-pressed.
   assign e1       = p1_fire & ~p1_q;
   assign e2       = p2_fire & ~p2_q;
   assign cnt_zero = (cnt == '0);
   assign p1_out   = (p1_lives == 2'd0);
   assign p2_out   = (p2_lives == 2'd0);

   // armed is clear for the first clock after reset release, which keeps a
   // start held through reset from being taken on that first edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         armed     <= 1'b0;
         p1_q      <= 1'b0;
         p2_q      <= 1'b0;
         draw      <= 1'b0;
         shot_p1   <= 1'b0;
         shot_p2   <= 1'b0;
         roundtime <= 1'b0;
         game_over <= 1'b0;
         winner    <= 2'b00;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         armed     <= 1'b1;
         p1_q      <= p1_fire;
         p2_q      <= p2_fire;
         draw      <= draw_nxt;
         shot_p1   <= shot_p1_nxt;
         shot_p2   <= shot_p2_nxt;
         roundtime <= roundtime_nxt;
         game_over <= game_over_nxt;
         winner    <= winner_nxt;
      end
   end

   // dec1/dec2 carry the shot decision out of COUNTDOWN/DRAW; they are only
   // non-zero on the cycle that moves to RESOLVE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      dec1      = 1'b0;
      dec2      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && armed) begin
               state_nxt = S_COUNTDOWN;
               cnt_nxt   = WAIT_LD;
            end
         end
         S_COUNTDOWN: begin
            if (e1 || e2) begin
               state_nxt = S_RESOLVE;
               cnt_nxt   = '0;
               dec1      = e1;
               dec2      = e2;
            end else if (cnt_zero) begin
               state_nxt = S_DRAW;
               cnt_nxt   = WINDOW_LD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_DRAW: begin
            if (e1 || e2) begin
               state_nxt = S_RESOLVE;
               cnt_nxt   = '0;
               dec1      = e2 & ~e1;
               dec2      = e1 & ~e2;
            end else if (cnt_zero) begin
               state_nxt = S_RESOLVE;
               dec1      = 1'b1;
               dec2      = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_RESOLVE: begin
            state_nxt = S_STROBE;
         end
         S_STROBE: begin
            state_nxt = S_RESULT;
            cnt_nxt   = RESULT_LD;
         end
         S_RESULT: begin
            if (cnt_zero) begin
               state_nxt = (p1_out || p2_out) ? S_GAMEOVER : S_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_GAMEOVER: begin
            state_nxt = S_GAMEOVER;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so each one
   // changes on the same edge as the state it belongs to.
   always_comb begin
      draw_nxt      = (state_nxt == S_DRAW);
      roundtime_nxt = (state_nxt == S_STROBE);
      game_over_nxt = (state_nxt == S_GAMEOVER);
      shot_p1_nxt   = 1'b0;
      shot_p2_nxt   = 1'b0;
      winner_nxt    = 2'b00;
      case (state)
         S_COUNTDOWN, S_DRAW: begin
            shot_p1_nxt = dec1;
            shot_p2_nxt = dec2;
         end
         S_RESOLVE, S_STROBE: begin
            shot_p1_nxt = shot_p1;
            shot_p2_nxt = shot_p2;
         end
         S_RESULT: begin
            if (!cnt_zero) begin
               shot_p1_nxt = shot_p1;
               shot_p2_nxt = shot_p2;
            end else if (state_nxt == S_GAMEOVER) begin
               winner_nxt = {p1_out, p2_out};
            end
         end
         S_GAMEOVER: begin
            winner_nxt = winner;
         end
         default: begin
            shot_p1_nxt = 1'b0;
            shot_p2_nxt = 1'b0;
         end
      endcase
   end

endmodule
